// File: rtl/tw64_sched_if.sv
// Stream bundle for the twiddle sequencer: sample input side and annotated sample output side.
// The slave modport is the sequencer's view and the master modport is the driver/sink's view.
interface tw64_sched_if #(
    parameter int DATA_WIDTH = 14
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_sof;
    logic signed [DATA_WIDTH-1:0] in_re;
    logic signed [DATA_WIDTH-1:0] in_im;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_re;
    logic signed [DATA_WIDTH-1:0] out_im;
    logic [5:0]                   out_index;
    logic [3:0]                   out_tw_idx;
    logic [8:0]                   out_tw_sel;
    logic                         out_swap;
    logic                         out_neg_cos;
    logic                         out_neg_sin;
    logic                         out_last;

    modport master (
        output in_valid, in_sof, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_tw_idx,
               out_tw_sel, out_swap, out_neg_cos, out_neg_sin, out_last
    );

    modport slave (
        input  in_valid, in_sof, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_tw_idx,
               out_tw_sel, out_swap, out_neg_cos, out_neg_sin, out_last
    );
endinterface

// File: rtl/tw64_sched.sv
// Twiddle sequencer for the 64-point radix-8 stage: tracks frame position, forms e = p*q,
// and folds it into a first-octant constant index plus swap/negate flags.
module tw64_sched #(
    parameter int DATA_WIDTH = 14,
    parameter bit INVERSE    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    tw64_sched_if.slave bus,
    input  logic        err_clr,
    output logic        sof_err
);
    logic                         ld1, ld2, accept, sof_set;
    logic [5:0]                   cnt, n, e_fwd, e;

    logic                         v1;
    logic [5:0]                   s1_idx, s1_e;
    logic signed [DATA_WIDTH-1:0] s1_re, s1_im;

    logic [2:0]                   oct, r;
    logic [3:0]                   m;
    logic [8:0]                   sel;

    logic                         v2;
    logic [5:0]                   o_idx;
    logic [3:0]                   o_m;
    logic [8:0]                   o_sel;
    logic                         o_swap, o_neg_cos, o_neg_sin, o_last;
    logic signed [DATA_WIDTH-1:0] o_re, o_im;

    // NOTE: in_ready depends only on pipeline state and out_ready, never on in_valid,
    // so a source that waits for in_ready before raising in_valid cannot form a loop.
    assign ld2          = !v2 || bus.out_ready;
    assign ld1          = !v1 || ld2;
    assign bus.in_ready = ld1;
    assign accept       = bus.in_valid && ld1;

    assign n       = bus.in_sof ? 6'd0 : cnt;
    assign e_fwd   = {3'b000, n[5:3]} * {3'b000, n[2:0]};
    assign e       = INVERSE ? (6'd0 - e_fwd) : e_fwd;
    assign sof_set = accept && bus.in_sof && (cnt != 6'd0);

    // Odd octants run backwards, so the constant index mirrors about 8.
    always_comb begin
        oct = s1_e[5:3];
        r   = s1_e[2:0];
        m   = oct[0] ? (4'd8 - {1'b0, r}) : {1'b0, r};
        sel = 9'd1 << m;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            sof_err <= 1'b0;
            v1      <= 1'b0;
            s1_idx  <= '0;
            s1_e    <= '0;
            s1_re   <= '0;
            s1_im   <= '0;
        end else begin
            if (accept)
                cnt <= n + 6'd1;
            if (sof_set)
                sof_err <= 1'b1;
            else if (err_clr)
                sof_err <= 1'b0;
            if (ld1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_idx <= n;
                    s1_e   <= e;
                    s1_re  <= bus.in_re;
                    s1_im  <= bus.in_im;
                end
            end
        end
    end

    // NOTE: output fields are reset (not just the valid bit) so the downstream
    // multiplier bank sees a defined constant select straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            o_idx     <= '0;
            o_m       <= '0;
            o_sel     <= 9'b000000001;
            o_swap    <= 1'b0;
            o_neg_cos <= 1'b0;
            o_neg_sin <= 1'b0;
            o_last    <= 1'b0;
            o_re      <= '0;
            o_im      <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                o_idx     <= s1_idx;
                o_m       <= m;
                o_sel     <= sel;
                o_swap    <= oct[0] ^ oct[1];
                o_neg_cos <= oct[1] ^ oct[2];
                o_neg_sin <= oct[2];
                o_last    <= (s1_idx == 6'd63);
                o_re      <= s1_re;
                o_im      <= s1_im;
            end
        end
    end

    assign bus.out_valid   = v2;
    assign bus.out_index   = o_idx;
    assign bus.out_tw_idx  = o_m;
    assign bus.out_tw_sel  = o_sel;
    assign bus.out_swap    = o_swap;
    assign bus.out_neg_cos = o_neg_cos;
    assign bus.out_neg_sin = o_neg_sin;
    assign bus.out_last    = o_last;
    assign bus.out_re      = o_re;
    assign bus.out_im      = o_im;
endmodule

// File: tb/tb_tw64_sched.sv
// Bench for tw64_sched: forward and inverse instances share one stimulus stream; a scoreboard
// model checks every output, a vector table checks known twiddle points, sequences cover corners.
module tb_tw64_sched;
    localparam int DW = 14;

    logic clk = 1'b0;
    logic rst, err_clr, sof_err, sof_err_i;
    int   errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tw64_sched_if #(.DATA_WIDTH(DW)) bus ();
    tw64_sched_if #(.DATA_WIDTH(DW)) bus_i ();

    assign bus_i.in_valid  = bus.in_valid;
    assign bus_i.in_sof    = bus.in_sof;
    assign bus_i.in_re     = bus.in_re;
    assign bus_i.in_im     = bus.in_im;
    assign bus_i.out_ready = bus.out_ready;

    tw64_sched #(.DATA_WIDTH(DW), .INVERSE(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr), .sof_err(sof_err));
    tw64_sched #(.DATA_WIDTH(DW), .INVERSE(1'b1)) dut_i (
        .clk(clk), .rst(rst), .bus(bus_i), .err_clr(err_clr), .sof_err(sof_err_i));

    logic [50:0] act_f, act_i;
    assign act_f = {bus.out_index, bus.out_tw_idx, bus.out_tw_sel, bus.out_swap,
                    bus.out_neg_cos, bus.out_neg_sin, bus.out_last, bus.out_re, bus.out_im};
    assign act_i = {bus_i.out_index, bus_i.out_tw_idx, bus_i.out_tw_sel, bus_i.out_swap,
                    bus_i.out_neg_cos, bus_i.out_neg_sin, bus_i.out_last, bus_i.out_re, bus_i.out_im};

    typedef struct {
        logic [50:0] f;
        logic [50:0] i;
        int          acc;
    } exp_t;

    typedef struct {
        int         n;
        bit         inv;
        logic [7:0] exp;   // {m, swap, neg_cos, neg_sin, last}
    } vec_t;

    exp_t       q[$];
    vec_t       vecs[11];
    int         mdl_cnt = 0;
    int         mn;
    bit         check_lat = 1'b0, log_en = 1'b0, bp_found;
    logic [7:0] fwd_log[64], inv_log[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent model: octant from the angle e, flags from the effective (cos, sin) table.
    function automatic logic [50:0] model(input int n, input bit inv,
                                          input logic [DW-1:0] re, input logic [DW-1:0] im);
        int         e, oct, m;
        logic [2:0] fl;
        logic [8:0] sel;
        e = (n / 8) * (n % 8);
        if (inv) e = (64 - e) % 64;
        oct = e / 8;
        m   = (oct % 2 == 1) ? 8 * (oct + 1) - e : e - 8 * oct;
        case (oct)
            0: fl = 3'b000;  1: fl = 3'b100;  2: fl = 3'b110;  3: fl = 3'b010;
            4: fl = 3'b011;  5: fl = 3'b111;  6: fl = 3'b101;  default: fl = 3'b001;
        endcase
        sel    = '0;
        sel[m] = 1'b1;
        return {6'(n), 4'(m), sel, fl, (n == 63), re, im};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mdl_cnt = 0;
        end else begin
            if (bus.out_valid || bus_i.out_valid) begin
                check("valid_match", bus_i.out_valid, bus.out_valid);
                if (q.size() == 0) begin
                    check("stale_output", {bus.out_valid, bus_i.out_valid}, 0);
                end else begin
                    check("fwd_sample", act_f, q[0].f);
                    check("inv_sample", act_i, q[0].i);
                    if (bus.out_ready) begin
                        if (check_lat) check("latency", cyc - q[0].acc, 2);
                        if (log_en) begin
                            fwd_log[bus.out_index] = {bus.out_tw_idx, bus.out_swap,
                                bus.out_neg_cos, bus.out_neg_sin, bus.out_last};
                            inv_log[bus.out_index] = {bus_i.out_tw_idx, bus_i.out_swap,
                                bus_i.out_neg_cos, bus_i.out_neg_sin, bus_i.out_last};
                        end
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mn      = bus.in_sof ? 0 : mdl_cnt;
                mdl_cnt = (mn + 1) % 64;
                q.push_back('{f: model(mn, 1'b0, bus.in_re, bus.in_im),
                              i: model(mn, 1'b1, bus.in_re, bus.in_im), acc: cyc});
            end
        end
    end

    task automatic send(input bit sof, input bit clr = 1'b0);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_re    = DW'($urandom);
        bus.in_im    = DW'($urandom);
        err_clr      = clr;
        @(negedge clk);
        for (int w = 0; w < 50 && !bus.in_ready; w++) @(negedge clk);
        if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_sof = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{9,  1'b0, 8'h10};
        vecs[1]  = '{20, 1'b0, 8'h88};
        vecs[2]  = '{36, 1'b0, 8'h0C};
        vecs[3]  = '{63, 1'b0, 8'h1B};
        vecs[4]  = '{9,  1'b1, 8'h12};
        vecs[5]  = '{0,  1'b1, 8'h00};
        vecs[6]  = '{0,  1'b0, 8'h00};
        vecs[7]  = '{63, 1'b1, 8'h19};
        vecs[8]  = '{27, 1'b0, 8'h78};
        vecs[9]  = '{45, 1'b0, 8'h74};
        vecs[10] = '{45, 1'b1, 8'h76};

        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_tw_sel", bus.out_tw_sel, 9'h001);
        check("rst_index_idx", {bus.out_index, bus.out_tw_idx}, 0);
        check("rst_flags", {bus.out_swap, bus.out_neg_cos, bus.out_neg_sin, bus.out_last}, 0);
        check("rst_data", {bus.out_re, bus.out_im}, 0);
        check("rst_sof_err", sof_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full forward frame with no stalls: fixed latency and a logged value per index.
        check_lat = 1'b1;
        log_en    = 1'b1;
        for (int i = 0; i < 64; i++) send(i == 0);
        idle(4);
        check_lat = 1'b0;
        log_en    = 1'b0;
        check("frame1_sof_err", sof_err, 0);
        for (int v = 0; v < 11; v++)
            check($sformatf("vec_n%0d_inv%0d", vecs[v].n, vecs[v].inv),
                  vecs[v].inv ? inv_log[vecs[v].n] : fwd_log[vecs[v].n], vecs[v].exp);

        // Backpressure: output n=3 is held for 5 cycles while input keeps coming.
        fork
            begin
                for (int i = 0; i < 10; i++) send(i == 0);
                idle(8);
            end
            begin
                bp_found = 1'b0;
                for (int w = 0; w < 30 && !bp_found; w++) begin
                    @(posedge clk);
                    #1;
                    bp_found = bus.out_valid && (bus.out_index == 6'd3);
                end
                check("bp_reach_n3", {bus.out_valid, bus.out_index}, {1'b1, 6'd3});
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready_low", bus.in_ready, 0);
                check("bp_hold", {bus.out_valid, bus.out_index}, {1'b1, 6'd3});
                bus.out_ready = 1'b1;
            end
        join
        check("bp_sof_err", sof_err, 0);

        // Early start of frame on the 11th sample.
        send(1'b1);
        @(posedge clk);
        #1;
        check("sof_out_index", {bus.out_valid, bus.out_index}, {1'b1, 6'd0});
        check("sof_err_set", sof_err, 1);
        idle(4);
        check("sof_err_sticky", sof_err, 1);
        send(1'b1, 1'b1);
        idle(3);
        check("sof_err_set_wins", sof_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("sof_err_cleared", sof_err, 0);

        // Rest of the frame plus a whole frame with no in_sof: the counter wraps on its own.
        for (int i = 0; i < 127; i++) send(1'b0);
        idle(4);
        check("wrap_sof_err", sof_err, 0);
        check("wrap_drained", q.size(), 0);

        // Reset mid-frame with both stages occupied.
        for (int i = 0; i <= 30; i++) send(i == 0);
        check("pre_rst_out", {bus.out_valid, bus.out_index}, {1'b1, 6'd29});
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        check("rst_async_valid", {bus.out_valid, bus_i.out_valid}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        check("post_rst_quiet", bus.out_valid, 0);
        send(1'b0);
        @(posedge clk);
        #1;
        check("post_rst_index", {bus.out_valid, bus.out_index}, {1'b1, 6'd0});
        idle(4);
        check("final_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tw64_sched.md
# tw64_sched

Sequencer for the 64-point radix-8 twiddle multiplication stage. It accepts a stream of complex samples and tracks each sample's position in the 64-sample frame. For each sample it computes the twiddle exponent and folds it into the first octant. It emits the sample with a constant-multiplier index (0..8), a matching one-hot select, and swap/negate flags. Downstream, the bank of nine fixed shift-add multipliers and the recombination adder use these to rebuild any of the 64 twiddles from the nine first-octant constants.

## Interface
Parameters:
- DATA_WIDTH, 14, width of each sample component (signed, two's complement).
- INVERSE, 0, 0 selects the forward twiddle W = exp(-j2πe/64); 1 selects the conjugate, using e' = (64 - e) mod 64.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_sof  in  1  start of frame; qualified by in_valid && in_ready.
- in_re, in_im  in  DATA_WIDTH each  sample components.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts the output this cycle.
- out_re, out_im  out  DATA_WIDTH each  sample, passed through unchanged.
- out_index  out  6  sample position n within the frame.
- out_tw_idx  out  4  first-octant constant index m, range 0..8.
- out_tw_sel  out  9  one-hot form of m; bit m is set.
- out_swap  out  1  swap the cos and sin roles.
- out_neg_cos  out  1  negate the cos term.
- out_neg_sin  out  1  negate the sin term.
- out_last  out  1  high when out_index == 63.
- err_clr  in  1  clears sof_err.
- sof_err  out  1  sticky flag; set when a frame is truncated.

## Operation
Frame counter:
- 6-bit counter cnt holds the index of the next sample.
- On each accepted sample, the sample's index is n = in_sof ? 0 : cnt, and cnt becomes n + 1 (mod 64).
- cnt wraps from 63 to 0 automatically; in_sof is not required.

Error flag:
- If in_sof is accepted while cnt != 0, sof_err is set.
- err_clr clears sof_err.
- If the set condition and err_clr occur in the same cycle, the set wins.

Exponent (stage 1):
- p = n[5:3], q = n[2:0], e = p*q, a 6-bit value with range 0..49.
- If INVERSE = 1, e is replaced by (64 - e) mod 64.

Octant fold (stage 2):
- oct = e[5:3], r = e[2:0].
- m = r when oct is even; m = 8 - r when oct is odd (so r = 0 in an odd octant gives m = 8).
- out_swap = oct[0] ^ oct[1].
- out_neg_cos = oct[1] ^ oct[2].
- out_neg_sin = oct[2].
- Meaning: with c = cos(2πm/64) and s = sin(2πm/64), cos θ = ±(swap ? s : c) and sin θ = ±(swap ? c : s), signs set by the neg flags.
- Per octant 0..7, the effective (cos, sin) is: (c,s), (s,c), (-s,c), (-c,s), (-c,-s), (-s,-c), (s,-c), (c,-s).

Data: in_re and in_im pass through unmodified, aligned with their control fields.

## Timing
Pipeline:
- Two register stages, v1 and v2; v2 drives out_valid.
- Latency is 2 cycles from acceptance to out_valid, given no stall.
- Throughput is one sample per cycle.

Advance rules:
- Stage 2 loads when !v2 || out_ready.
- Stage 1 loads when !v1 || stage 2 loads.
- in_ready = !v1 || !v2 || out_ready. This is combinational from out_ready; there is no combinational path from in_valid.

Stall behaviour:
- While out_valid && !out_ready, all output fields hold stable.
- No sample is dropped or duplicated.

Reset values:
- v1, v2, out_valid, cnt and sof_err are 0.
- in_ready is 1 after reset.
- All out_* data and control fields are 0, except out_tw_sel = 9'b000000001.

Reset mid-frame: the pipeline is flushed and in-flight samples are lost. The next accepted sample gets index 0.

cnt changes only on accepted samples; stalls do not advance it.

## Test plan
- Forward stream, 64 samples, out_ready = 1:
  - n=9 → e=1, m=1, swap/neg_cos/neg_sin = 0/0/0.
  - n=20 → e=8, m=8, swap=1.
  - n=36 → e=16, m=0, swap=1, neg_cos=1.
  - n=63 → e=49, m=1, swap=1, neg_sin=1, out_last=1.
  - Each output appears exactly 2 cycles after input.
- INVERSE=1, n=9 → e'=63, m=1, swap=0, neg_cos=0, neg_sin=1. n=0 → m=0, all flags 0.
- Backpressure: continuous in_valid; out_ready low for 5 cycles starting at n=3.
  - in_ready falls after the pipeline fills.
  - Output n=3 is held stable.
  - On release, indices continue 3, 4, 5… with no gaps or repeats.
- in_sof on the 11th sample (cnt=10):
  - That sample reports out_index=0 and sof_err=1.
  - sof_err stays set until err_clr; with err_clr and a new set in the same cycle, it stays 1.
- Two back-to-back frames with no in_sof: the second frame starts at index 0 after 63, and sof_err stays 0.
- rst pulsed at n=30 with both stages valid:
  - out_valid drops immediately (asynchronous).
  - The first sample after release reports index 0, and no stale output appears.
